// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the 4:1 mux round-robin arbiter: FSM encodings and channel indices.
package mux4_rr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/select/handshake bundle between the sources, the arbiter and the mux consumer.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       ready;
    logic       S0;
    logic       S1;
    logic       valid;
    logic [3:0] grant;
    logic       last;

    modport master (
        input  req, ready,
        output S0, S1, valid, grant, last
    );

    modport slave (
        output req, ready,
        input  S0, S1, valid, grant, last
    );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin finder: first set req bit scanning ptr+1, ptr+2, ptr+3, ptr.
// Latency: zero (pure combinational); no backpressure.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] idx_o,
    output logic       any_o
);
    logic [1:0] cand;

    always_comb begin
        idx_o = ptr_i;
        cand  = ptr_i;
        any_o = |req_i;
        // Walk from the lowest priority upward so the highest-priority hit is written last.
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_i + 2'(k);
            if (req_i[cand]) idx_o = cand;
        end
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter driving the 4:1 mux selects with a valid/ready beat handshake.
// Latency: grant 1 cycle after req; ready=0 stalls the burst in place, never forces rotation.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.master bus
);
    logic [0:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       sel_req;
    logic       in_grant;
    logic       is_last;
    logic       accept;
    logic       end_grant;
    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_any;

    assign in_grant  = (state_q == ST_GRANT);
    assign sel_req   = bus.req[sel_q];
    assign is_last   = (cnt_q == CNT_W'(BURST_LEN - 1));
    assign bus.valid = in_grant & sel_req;
    assign bus.last  = bus.valid & is_last;
    assign accept    = bus.valid & bus.ready;
    assign end_grant = in_grant & (~sel_req | (accept & is_last));

    // Scanning from sel after a grant puts the current owner last, so it only wins when alone.
    assign pick_ptr  = in_grant ? sel_q : ptr_q;

    rr_pick4 u_pick (
        .req_i (bus.req),
        .ptr_i (pick_ptr),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        if (!in_grant) begin
            if (pick_any) begin
                state_d = ST_GRANT;
                sel_d   = pick_idx;
                grant_d = onehot4(pick_idx);
                cnt_d   = '0;
            end
        end else if (end_grant) begin
            ptr_d = sel_q;
            cnt_d = '0;
            if (pick_any) begin
                sel_d   = pick_idx;
                grant_d = onehot4(pick_idx);
            end else begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= CH_A;
            ptr_q   <= CH_D;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.S0    = sel_q[0];
    assign bus.S1    = sel_q[1];
    assign bus.grant = grant_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with BURST_LEN=4: reset, rotation, stall, withdrawal, sole and sparse requesters.
module tb_mux4_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.req   = 4'b0000;
        bus.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
        repeat (6) tick();
        #1;
        total++;
        if ({bus.S1, bus.S0} !== 2'b01) begin
            bad++; $display("FAIL rst_pre_sel got=%b want=01", {bus.S1, bus.S0});
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus.S1, bus.S0} !== 2'b00) begin
            bad++; $display("FAIL rst_sel got=%b want=00", {bus.S1, bus.S0});
        end
        total++;
        if (bus.grant !== 4'b0000) begin
            bad++; $display("FAIL rst_grant got=%b want=0000", bus.grant);
        end
        total++;
        if (bus.valid !== 1'b0 || bus.last !== 1'b0) begin
            bad++; $display("FAIL rst_valid_last got=%b%b want=00", bus.valid, bus.last);
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (bus.valid !== 1'b0) begin
            bad++; $display("FAIL rst_idle_valid got=%b want=0", bus.valid);
        end
        tick();
        #1;
        total++;
        if (bus.grant !== 4'b0001 || {bus.S1, bus.S0} !== 2'b00 || bus.valid !== 1'b1) begin
            bad++; $display("FAIL rst_first_grant got=%b/%b/%b want=0001/00/1",
                            bus.grant, {bus.S1, bus.S0}, bus.valid);
        end
    endtask

    task automatic test_rotation();
        int ch;
        do_reset();
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
        #1;
        total++;
        if (bus.valid !== 1'b0) begin
            bad++; $display("FAIL rot_idle_valid got=%b want=0", bus.valid);
        end
        for (int b = 0; b < 20; b++) begin
            tick();
            #1;
            ch = (b / 4) % 4;
            total++;
            if (bus.grant !== (4'b0001 << ch) || {bus.S1, bus.S0} !== 2'(ch)) begin
                bad++; $display("FAIL rot_grant beat=%0d got=%b/%b want_ch=%0d",
                                b, bus.grant, {bus.S1, bus.S0}, ch);
            end
            total++;
            if (bus.valid !== 1'b1 || bus.last !== ((b % 4) == 3)) begin
                bad++; $display("FAIL rot_valid_last beat=%0d got=%b%b want=1%b",
                                b, bus.valid, bus.last, ((b % 4) == 3));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.req   = 4'b1100;
        bus.ready = 1'b1;
        tick();
        #1;
        total++;
        if ({bus.S1, bus.S0} !== 2'b10 || bus.grant !== 4'b0100 || bus.valid !== 1'b1) begin
            bad++; $display("FAIL stall_grant got=%b/%b/%b want=10/0100/1",
                            {bus.S1, bus.S0}, bus.grant, bus.valid);
        end
        tick();
        tick();
        bus.ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.S1, bus.S0} !== 2'b10 || bus.last !== 1'b0 || bus.valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%b want=10/0/1",
                                i, {bus.S1, bus.S0}, bus.last, bus.valid);
            end
            if (i < 4) begin
                tick();
                #1;
            end
        end
        tick();
        bus.ready = 1'b1;
        #1;
        total++;
        if (bus.last !== 1'b0) begin
            bad++; $display("FAIL stall_beat3_last got=%b want=0", bus.last);
        end
        tick();
        #1;
        total++;
        if (bus.last !== 1'b1 || {bus.S1, bus.S0} !== 2'b10) begin
            bad++; $display("FAIL stall_beat4_last got=%b/%b want=1/10", bus.last, {bus.S1, bus.S0});
        end
        tick();
        #1;
        total++;
        if ({bus.S1, bus.S0} !== 2'b11 || bus.grant !== 4'b1000 || bus.last !== 1'b0) begin
            bad++; $display("FAIL stall_rotate got=%b/%b/%b want=11/1000/0",
                            {bus.S1, bus.S0}, bus.grant, bus.last);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.req   = 4'b1010;
        bus.ready = 1'b1;
        tick();
        #1;
        total++;
        if (bus.grant !== 4'b0010) begin
            bad++; $display("FAIL wd_grant1 got=%b want=0010", bus.grant);
        end
        tick();
        tick();
        bus.req = 4'b1000;
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.last !== 1'b0 || bus.grant !== 4'b0010) begin
            bad++; $display("FAIL wd_drop got=%b/%b/%b want=0/0/0010", bus.valid, bus.last, bus.grant);
        end
        tick();
        #1;
        total++;
        if ({bus.S1, bus.S0} !== 2'b11 || bus.grant !== 4'b1000 || bus.valid !== 1'b1) begin
            bad++; $display("FAIL wd_next got=%b/%b/%b want=11/1000/1",
                            {bus.S1, bus.S0}, bus.grant, bus.valid);
        end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (bus.last !== (b == 3)) begin
                bad++; $display("FAIL wd_cnt beat=%0d last got=%b want=%b", b, bus.last, (b == 3));
            end
            if (b < 3) begin
                tick();
                #1;
            end
        end
    endtask

    task automatic test_sole();
        do_reset();
        bus.req   = 4'b0100;
        bus.ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            tick();
            #1;
            total++;
            if (bus.valid !== 1'b1 || bus.grant !== 4'b0100 || {bus.S1, bus.S0} !== 2'b10
                || bus.last !== ((b % 4) == 3)) begin
                bad++; $display("FAIL sole beat=%0d got=%b/%b/%b/%b want=1/0100/10/%b",
                                b, bus.valid, bus.grant, {bus.S1, bus.S0}, bus.last, ((b % 4) == 3));
            end
        end
    endtask

    task automatic test_sparse();
        do_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            total++;
            if (bus.valid !== 1'b0 || bus.grant !== 4'b0000) begin
                bad++; $display("FAIL sparse_idle cyc=%0d got=%b/%b want=0/0000", i, bus.valid, bus.grant);
            end
        end
        tick();
        bus.req = 4'b1000;
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.grant !== 4'b0000) begin
            bad++; $display("FAIL sparse_req_cyc got=%b/%b want=0/0000", bus.valid, bus.grant);
        end
        tick();
        #1;
        total++;
        if (bus.grant !== 4'b1000 || {bus.S1, bus.S0} !== 2'b11 || bus.valid !== 1'b1) begin
            bad++; $display("FAIL sparse_grant got=%b/%b/%b want=1000/11/1",
                            bus.grant, {bus.S1, bus.S0}, bus.valid);
        end
        bus.req = 4'b0000;
        #1;
        total++;
        if (bus.valid !== 1'b0) begin
            bad++; $display("FAIL sparse_drop_valid got=%b want=0", bus.valid);
        end
        tick();
        #1;
        total++;
        if (bus.grant !== 4'b0000 || {bus.S1, bus.S0} !== 2'b11 || bus.valid !== 1'b0) begin
            bad++; $display("FAIL sparse_back_idle got=%b/%b/%b want=0000/11/0",
                            bus.grant, {bus.S1, bus.S0}, bus.valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.req   = 4'b0000;
        bus.ready = 1'b0;
        test_reset();
        test_rotation();
        test_stall();
        test_withdraw();
        test_sole();
        test_sparse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 mux. Four sources drive the mux data inputs A..D and raise a request line each.
- The block grants one source at a time and drives the mux select lines S1/S0 for that source. It frames each grant as a burst of at most BURST_LEN beats, with a valid/ready handshake toward the consumer of the mux output Z.

Parameters:
- BURST_LEN, 4, maximum accepted beats per grant before the arbiter rotates to the next requester (legal range 1..2**CNT_W).
- CNT_W, 3, width of the beat counter; must satisfy 2**CNT_W >= BURST_LEN.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per channel; bit0=A, bit1=B, bit2=C, bit3=D
- ready  input  1  consumer accepts the current beat of Z
- S0  output  1  mux select LSB (registered)
- S1  output  1  mux select MSB (registered)
- valid  output  1  Z currently carries a beat from the granted channel
- grant  output  4  one-hot grant, registered, equals decode of {S1,S0} while in GRANT, else 0
- last  output  1  current beat is the final beat of this burst (BURST_LEN-th beat)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, {S1,S0}=2'b00, grant=4'b0000, valid=0, last=0, beat counter=0.
  - Priority pointer ptr=3, so channel 0 wins first.
- State IDLE:
  - valid=0, grant=0. {S1,S0} hold their last value.
  - If req!=0, pick the first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Load {S1,S0} with that index and set grant, counter=0, go to GRANT. Grant latency is 1 cycle from req seen.
- State GRANT:
  - valid = req[sel] (combinational from the registered sel).
  - last = valid & (counter==BURST_LEN-1).
  - A beat is accepted when valid & ready; counter increments on each accepted beat.
  - {S1,S0} and grant are stable for the whole GRANT.
- Leaving GRANT: on the accepted beat with last=1, or in any cycle where req[sel]=0 (requester withdrew):
  - Set ptr=sel.
  - If another channel requests (req with bit sel masked out for the last-beat case), load the next winner and stay in GRANT with counter=0. There is no idle bubble between back-to-back grants.
  - Otherwise go to IDLE.
  - If the only requester is the same channel after a last beat, it is re-granted immediately (fresh burst, counter=0).
- Stalls: ready=0 holds counter, sel and last indefinitely; a stall never forces rotation.
- Withdrawal: req[sel] dropping mid-burst ends the grant even if counter<BURST_LEN-1. Partial bursts are legal.
- BURST_LEN=1: every accepted beat is last; arbitration rotates every beat.
- New requests arriving during a grant are only considered at the rotation point. Fairness: no channel waits more than 3 bursts.
- Reset mid-burst: all outputs return to reset values asynchronously. The burst is abandoned without a last beat.
- Outputs S0, S1 and grant are glitch-free (registered). valid and last are combinational from registered state plus req/counter only, never from ready.

Decomposition:
- Shared package: state encodings (IDLE=1'b0, GRANT=1'b1) and the channel index constants CH_A..CH_D = 0..3.
- One natural sub-module: rr_pick4, a combinational round-robin next-index finder. Inputs req[3:0], ptr[1:0]; outputs idx[1:0] and any. It is used for both the IDLE and back-to-back decisions.

Test Plan:
- Reset: assert rst mid-cycle with req=4'b1111 -> S1S0=00, grant=0000, valid=0, last=0 immediately. After release, the first grant is channel 0 one cycle later.
- Rotation, all requesting: req=4'b1111, ready=1, BURST_LEN=4 -> grants 0,1,2,3,0 in 4-beat bursts. last on beats 4, 8, 12, 16. No valid gap between bursts.
- Stall: grant ch2 (S1S0=10), ready=0 for 5 cycles after beat 2 -> counter holds at 2, S1S0 stays 10. Burst completes 2 beats after ready returns.
- Withdrawal: ch1 granted, req[1] drops after 2 accepted beats while req[3]=1 -> valid=0 that cycle. The next cycle grants ch3 (S1S0=11), counter=0.
- Sole requester: req=4'b0100 only -> ch2 re-granted back-to-back every 4 beats. valid stays continuously 1 with ready=1.
- Sparse/idle: req=0 for 3 cycles, then req=4'b1000 -> IDLE throughout with valid=0, then grant=1000 exactly 1 cycle after req rises.
